// File: rtl/hazard_control_pkg.sv
// hazard_control_pkg: shared types and constants for the pipeline hazard controller.
// Latency: n/a (types only).
// Backpressure: n/a.
package hazard_control_pkg;

  // Encodings are visible on the hazard_state output port.
  typedef enum logic [1:0] {
    HAZ_RUN   = 2'd0,
    HAZ_FLUSH = 2'd1,
    HAZ_WAIT  = 2'd2
  } haz_state_t;

  // Width of the branch-penalty down-counter (penalty range 1..15).
  localparam int PEN_W = 4;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
// Latency: count reflects inc/clr one clock after they are sampled.
// Backpressure: none; clr wins over inc, count sticks at all-ones.
// Ports: clock, reset (async, active-high), inc, clr -> count[WIDTH-1:0].
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/hazard_control.sv
// hazard_control: hold/flush controller for the 5-stage pipeline (branch flush, load-use, mem wait).
// Latency: hold/flush outputs are combinational from state and inputs; state moves on each clock.
// Backpressure: mem_busy freezes the whole front of the pipe (all holds) and bubbles MEM/WB.
// Ports:
//   clock, reset                      clock and async active-high reset
//   id_rs1/id_rs2, id_uses_rs1/rs2    source registers of the instruction in ID
//   ex_rd, ex_reg_write, ex_mem_read  destination / load info of the instruction in EX
//   ex_should_branch                  taken branch/jump resolved in EX
//   mem_busy                          data memory / peripheral not ready
//   clear_counters                    synchronous clear of the performance counters
//   *_hold, *_flush                   per pipeline-register hold and bubble controls
//   hazard_state                      current FSM state
//   stall_cycles, flush_cycles        saturating performance counters
module hazard_control
  import hazard_control_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int BRANCH_PENALTY = 2,
  parameter int COUNTER_WIDTH  = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_uses_rs1,
  input  logic                      id_uses_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      ex_reg_write,
  input  logic                      ex_mem_read,
  input  logic                      ex_should_branch,
  input  logic                      mem_busy,
  input  logic                      clear_counters,
  output logic                      pc_hold,
  output logic                      if_id_hold,
  output logic                      id_ex_hold,
  output logic                      ex_mem_hold,
  output logic                      if_id_flush,
  output logic                      id_ex_flush,
  output logic                      mem_wb_flush,
  output logic [1:0]                hazard_state,
  output logic [COUNTER_WIDTH-1:0]  stall_cycles,
  output logic [COUNTER_WIDTH-1:0]  flush_cycles
);

  localparam logic [PEN_W-1:0] PEN_RELOAD = PEN_W'(BRANCH_PENALTY - 1);
  localparam logic [PEN_W-1:0] PEN_ONE    = PEN_W'(1);

  haz_state_t       state_q, state_d;
  haz_state_t       ret_q, ret_d;     // state to resume once mem_busy drops
  haz_state_t       eff_state;        // state whose behaviour applies this cycle
  logic [PEN_W-1:0] pen_q, pen_d;
  logic             load_use;

  assign load_use = ex_mem_read && ex_reg_write && (ex_rd != '0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  // In WAIT the saved state decides outputs, so release acts exactly like
  // the interrupted cycle and the transition out of WAIT happens on that edge.
  assign eff_state = (state_q == HAZ_WAIT) ? ret_q : state_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= HAZ_RUN;
      ret_q   <= HAZ_RUN;
      pen_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      pen_q   <= pen_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    pen_d        = pen_q;
    pc_hold      = 1'b0;
    if_id_hold   = 1'b0;
    id_ex_hold   = 1'b0;
    ex_mem_hold  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;

    if (reset) begin
      // Keep bubbles flowing into IF/ID and ID/EX while the core is in reset.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (mem_busy) begin
      // Freeze everything up to EX/MEM; a branch in EX is re-seen after release.
      pc_hold      = 1'b1;
      if_id_hold   = 1'b1;
      id_ex_hold   = 1'b1;
      ex_mem_hold  = 1'b1;
      mem_wb_flush = 1'b1;
      state_d      = HAZ_WAIT;
      if (state_q != HAZ_WAIT) begin
        ret_d = state_q;
      end
    end else begin
      state_d = eff_state;
      case (eff_state)
        HAZ_FLUSH: begin
          // EX holds a bubble here, so branch and load-use inputs are ignored.
          if_id_flush = 1'b1;
          if (pen_q <= PEN_ONE) begin
            state_d = HAZ_RUN;
            pen_d   = '0;
          end else begin
            pen_d = pen_q - PEN_ONE;
          end
        end
        default: begin
          if (ex_should_branch) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (BRANCH_PENALTY > 1) begin
              state_d = HAZ_FLUSH;
              pen_d   = PEN_RELOAD;
            end
          end else if (load_use) begin
            pc_hold     = 1'b1;
            if_id_hold  = 1'b1;
            id_ex_flush = 1'b1;
          end
        end
      endcase
    end
  end

  assign hazard_state = state_q;

  sat_counter #(.WIDTH(COUNTER_WIDTH)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (pc_hold && !reset),
    .clr   (clear_counters),
    .count (stall_cycles)
  );

  sat_counter #(.WIDTH(COUNTER_WIDTH)) u_flush_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (if_id_flush && !reset),
    .clr   (clear_counters),
    .count (flush_cycles)
  );

endmodule

// File: tb/tb_hazard_control.sv
// tb_hazard_control: directed vector table plus hand sequences for hazard_control.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_hazard_control;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_reg_write, ex_mem_read;
  logic       ex_should_branch, mem_busy, clear_counters;

  logic       pc_hold, if_id_hold, id_ex_hold, ex_mem_hold;
  logic       if_id_flush, id_ex_flush, mem_wb_flush;
  logic [1:0] hazard_state;
  logic [3:0] stall_cycles, flush_cycles;

  logic       p3_pc_hold, p3_if_id_hold, p3_id_ex_hold, p3_ex_mem_hold;
  logic       p3_if_id_flush, p3_id_ex_flush, p3_mem_wb_flush;
  logic [1:0] p3_state;
  logic [7:0] p3_stall, p3_flush;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  hazard_control #(.REG_ADDR_WIDTH(5), .BRANCH_PENALTY(2), .COUNTER_WIDTH(4)) dut (
    .clock(clock), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_should_branch(ex_should_branch), .mem_busy(mem_busy), .clear_counters(clear_counters),
    .pc_hold(pc_hold), .if_id_hold(if_id_hold), .id_ex_hold(id_ex_hold), .ex_mem_hold(ex_mem_hold),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_wb_flush(mem_wb_flush),
    .hazard_state(hazard_state), .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
  );

  hazard_control #(.REG_ADDR_WIDTH(5), .BRANCH_PENALTY(3), .COUNTER_WIDTH(8)) dut_p3 (
    .clock(clock), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_should_branch(ex_should_branch), .mem_busy(mem_busy), .clear_counters(clear_counters),
    .pc_hold(p3_pc_hold), .if_id_hold(p3_if_id_hold), .id_ex_hold(p3_id_ex_hold),
    .ex_mem_hold(p3_ex_mem_hold), .if_id_flush(p3_if_id_flush), .id_ex_flush(p3_id_ex_flush),
    .mem_wb_flush(p3_mem_wb_flush), .hazard_state(p3_state),
    .stall_cycles(p3_stall), .flush_cycles(p3_flush)
  );

  // Output bit order: {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, if_id_flush, id_ex_flush, mem_wb_flush}
  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       br;
    logic       busy;
    logic [6:0] exp_o;
    logic [1:0] exp_st;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                              input logic u2, input logic [4:0] rd, input logic rw, input logic mr,
                              input logic br, input logic busy, input logic [6:0] o,
                              input logic [1:0] st);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd; v.rw = rw; v.mr = mr;
    v.br = br; v.busy = busy; v.exp_o = o; v.exp_st = st;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [6:0] outs();
    return {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, if_id_flush, id_ex_flush, mem_wb_flush};
  endfunction

  task automatic idle_inputs();
    id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rd = '0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
    ex_should_branch = 1'b0; mem_busy = 1'b0; clear_counters = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin : main
    int exp_stall;
    int exp_flush;

    // Load-use pattern: ID add x6,x5,x1 against EX lw x5.
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 2'd0);
    vecs[1]  = mk(5, 1, 1, 1, 5, 1, 1, 0, 0, 7'b1100010, 2'd0);
    vecs[2]  = mk(5, 1, 1, 1, 0, 0, 0, 0, 0, 7'b0000000, 2'd0);
    vecs[3]  = mk(0, 1, 1, 0, 0, 1, 1, 0, 0, 7'b0000000, 2'd0);
    vecs[4]  = mk(5, 1, 0, 1, 5, 1, 1, 0, 0, 7'b0000000, 2'd0);
    vecs[5]  = mk(1, 5, 1, 1, 5, 1, 1, 0, 0, 7'b1100010, 2'd0);
    vecs[6]  = mk(5, 1, 1, 1, 5, 0, 1, 0, 0, 7'b0000000, 2'd0);
    // Taken branch, penalty 2; load-use in FLUSH is ignored.
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b0000110, 2'd0);
    vecs[8]  = mk(5, 1, 1, 1, 5, 1, 1, 0, 0, 7'b0000100, 2'd1);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 2'd0);
    // mem_busy together with branch; branch taken after release; branch in FLUSH ignored.
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 7'b1111001, 2'd0);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 7'b1111001, 2'd2);
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b0000110, 2'd2);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b0000100, 2'd1);
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 2'd0);
    // Branch beats load-use; mem_busy for 3 cycles while FLUSH has one cycle left.
    vecs[15] = mk(5, 1, 1, 1, 5, 1, 1, 1, 0, 7'b0000110, 2'd0);
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 7'b1111001, 2'd1);
    vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 7'b1111001, 2'd2);
    vecs[18] = mk(5, 1, 1, 1, 5, 1, 1, 0, 1, 7'b1111001, 2'd2);
    vecs[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000100, 2'd2);
    vecs[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 2'd0);

    // Reset state
    idle_inputs();
    reset = 1'b1;
    #1;
    repeat (2) next_cycle();
    check("reset_outs", 32'(outs()), 32'(7'b0000110));
    check("reset_state", 32'(hazard_state), 32'd0);
    check("reset_stall", 32'(stall_cycles), 32'd0);
    check("reset_flush", 32'(flush_cycles), 32'd0);
    reset = 1'b0;
    next_cycle();

    // Table-driven vectors, counters tracked by the bench
    exp_stall = 0;
    exp_flush = 0;
    for (int i = 0; i < NVEC; i++) begin
      id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
      id_uses_rs1 = vecs[i].u1; id_uses_rs2 = vecs[i].u2;
      ex_rd = vecs[i].rd; ex_reg_write = vecs[i].rw; ex_mem_read = vecs[i].mr;
      ex_should_branch = vecs[i].br; mem_busy = vecs[i].busy;
      #2;
      check($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vecs[i].exp_o));
      check($sformatf("vec%0d_state", i), 32'(hazard_state), 32'(vecs[i].exp_st));
      next_cycle();
      if (vecs[i].exp_o[6] && exp_stall < 15) exp_stall++;
      if (vecs[i].exp_o[2] && exp_flush < 15) exp_flush++;
      check($sformatf("vec%0d_stall_cnt", i), 32'(stall_cycles), 32'(exp_stall));
      check($sformatf("vec%0d_flush_cnt", i), 32'(flush_cycles), 32'(exp_flush));
    end
    idle_inputs();

    // Reset pulse mid-FLUSH
    ex_should_branch = 1'b1;
    next_cycle();
    ex_should_branch = 1'b0;
    check("rstflush_pre_state", 32'(hazard_state), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rstflush_state", 32'(hazard_state), 32'd0);
    check("rstflush_outs", 32'(outs()), 32'(7'b0000110));
    check("rstflush_stall", 32'(stall_cycles), 32'd0);
    check("rstflush_flush", 32'(flush_cycles), 32'd0);
    next_cycle();
    reset = 1'b0;
    #2;
    check("rstflush_after_outs", 32'(outs()), 32'(7'b0000000));
    next_cycle();
    check("rstflush_after_state", 32'(hazard_state), 32'd0);
    check("rstflush_after_flush", 32'(flush_cycles), 32'd0);

    // Saturation of a 4-bit stall counter, then clear while still stalling
    clear_counters = 1'b1;
    next_cycle();
    clear_counters = 1'b0;
    check("sat_cleared", 32'(stall_cycles), 32'd0);
    mem_busy = 1'b1;
    repeat (14) @(posedge clock);
    #1;
    check("sat_14", 32'(stall_cycles), 32'd14);
    repeat (6) @(posedge clock);
    #1;
    check("sat_20", 32'(stall_cycles), 32'd15);
    check("sat_wide_20", 32'(p3_stall), 32'd20);
    clear_counters = 1'b1;
    next_cycle();
    clear_counters = 1'b0;
    check("sat_clr_wins", 32'(stall_cycles), 32'd0);
    mem_busy = 1'b0;
    next_cycle();
    check("sat_release_state", 32'(hazard_state), 32'd0);
    check("sat_release_stall", 32'(stall_cycles), 32'd0);

    // Penalty 3 instance: three IF/ID flush cycles per branch
    clear_counters = 1'b1;
    next_cycle();
    clear_counters = 1'b0;
    ex_should_branch = 1'b1;
    #2;
    check("p3_c0_flush", 32'({p3_if_id_flush, p3_id_ex_flush}), 32'(2'b11));
    check("p3_c0_state", 32'(p3_state), 32'd0);
    next_cycle();
    ex_should_branch = 1'b0;
    #2;
    check("p3_c1_flush", 32'({p3_if_id_flush, p3_id_ex_flush}), 32'(2'b10));
    check("p3_c1_state", 32'(p3_state), 32'd1);
    check("p2_c1_flush", 32'({if_id_flush, id_ex_flush}), 32'(2'b10));
    next_cycle();
    #2;
    check("p3_c2_flush", 32'({p3_if_id_flush, p3_id_ex_flush}), 32'(2'b10));
    check("p3_c2_state", 32'(p3_state), 32'd1);
    check("p2_c2_flush", 32'({if_id_flush, id_ex_flush}), 32'(2'b00));
    next_cycle();
    #2;
    check("p3_c3_flush", 32'({p3_if_id_flush, p3_id_ex_flush}), 32'(2'b00));
    check("p3_c3_state", 32'(p3_state), 32'd0);
    check("p3_flush_cnt", 32'(p3_flush), 32'd3);
    check("p2_flush_cnt", 32'(flush_cycles), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
